dm_param: RTL and testbench

//   Parametrised data memory for the single-cycle datapath: generalises the 8x256 DM to

---
 rtl/dm_param.sv | 159 +++++++++++++++
 tb/tb_dm_param.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/dm_param.sv
// ---------------------------------------------------------------------------
// dm_param : parametrised data memory for the single-cycle datapath.
//
// After reset a clear sequencer walks the whole array, one word per cycle,
// loading WORD0_INIT into word 0 and zero everywhere else. Once the clear is
// done the memory serves byte-lane writes and registered reads (latency 1)
// with a read_valid strobe. Requests to addresses at or above DEPTH are
// dropped (writes) or return zero (reads), and flag addr_err one cycle later.
//
// Parameters
//   DATA_W      word width, multiple of 8 (NB = DATA_W/8 byte lanes)
//   ADDR_W      address width
//   DEPTH       number of words, 1 <= DEPTH <= 2**ADDR_W
//   WORD0_INIT  value the clear sequence loads into word 0
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous active-high reset, restarts the clear sequence
//   mem_write   write request
//   mem_read    read request
//   address     word address
//   write_data  write data
//   byte_en     per-lane write enable, bit i covers write_data[8i+7:8i]
//   read_data   registered read data, holds when no read is accepted
//   read_valid  1-cycle pulse, read_data updated this cycle
//   busy        clear sequence in progress, requests ignored
//   addr_err    1-cycle pulse, previous accepted request was out of range
//
// state | meaning
// ------+-----------------------------------------------------------
// INIT  | clear sequence running, one word written per cycle, busy=1
// READY | normal operation, terminal until the next reset
// ---------------------------------------------------------------------------
module dm_param #(
   parameter int                 DATA_W     = 8,
   parameter int                 ADDR_W     = 8,
   parameter int                 DEPTH      = 256,
   parameter logic [DATA_W-1:0]  WORD0_INIT = 'hFF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mem_write,
   input  logic                  mem_read,
   input  logic [ADDR_W-1:0]     address,
   input  logic [DATA_W-1:0]     write_data,
   input  logic [DATA_W/8-1:0]   byte_en,
   output logic [DATA_W-1:0]     read_data,
   output logic                  read_valid,
   output logic                  busy,
   output logic                  addr_err
);

   localparam int NB = DATA_W / 8;

   // Last clear address, and DEPTH widened by one bit so the range compare
   // also works when DEPTH == 2**ADDR_W.
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [DATA_W-1:0]   read_data_q, read_data_d;
   logic                read_valid_q, read_valid_d;
   logic                addr_err_q, addr_err_d;

   logic [DATA_W-1:0]   mem [DEPTH];

   // Single write port shared by the clear sequencer and the request path.
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_addr;
   logic [DATA_W-1:0]   mem_wdata;
   logic [NB-1:0]       mem_be;

   logic                in_range;
   logic                req_ok;

   assign in_range = ({1'b0, address} < DEPTH_EXT);
   // Requests only count in READY and never in a reset cycle.
   assign req_ok   = (state_q == READY) && !reset;

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      read_data_d  = read_data_q;
      read_valid_d = 1'b0;
      addr_err_d   = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = address;
      mem_wdata    = write_data;
      mem_be       = byte_en;

      case (state_q)
         INIT: begin
            mem_we    = !reset;
            mem_addr  = ptr_q;
            mem_wdata = (ptr_q == '0) ? WORD0_INIT : '0;
            mem_be    = '1;
            ptr_d     = ptr_q + 1'b1;
            if (ptr_q == LAST_ADDR) begin
               state_d = READY;
            end
         end
         READY: begin
            if (req_ok) begin
               mem_we = mem_write && in_range;
               // Array is read combinationally here, before this edge's
               // write lands, which gives read-before-write for free.
               if (mem_read) begin
                  read_valid_d = 1'b1;
                  read_data_d  = in_range ? mem[address] : '0;
               end
               addr_err_d = (mem_write || mem_read) && !in_range;
            end
         end
         default: begin
            state_d = INIT;
            ptr_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= INIT;
         ptr_q        <= '0;
         read_data_q  <= '0;
         read_valid_q <= 1'b0;
         addr_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         read_data_q  <= read_data_d;
         read_valid_q <= read_valid_d;
         addr_err_q   <= addr_err_d;
      end
   end

   // Array storage carries no reset; contents are defined by the clear.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < NB; i++) begin
            if (mem_be[i]) begin
               mem[mem_addr][i*8 +: 8] <= mem_wdata[i*8 +: 8];
            end
         end
      end
   end

   assign read_data  = read_data_q;
   assign read_valid = read_valid_q;
   assign addr_err   = addr_err_q;
   assign busy       = (state_q == INIT);

endmodule

// File: tb/tb_dm_param.sv
module tb_dm_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: default 8x256 configuration.
   logic        reset_a, we_a, re_a;
   logic [7:0]  addr_a, wd_a, rd_a;
   logic [0:0]  be_a;
   logic        rv_a, busy_a, err_a;

   // Instance B: 32-bit words, 200 deep, exercises lanes and out-of-range.
   logic        reset_b, we_b, re_b;
   logic [7:0]  addr_b;
   logic [31:0] wd_b, rd_b;
   logic [3:0]  be_b;
   logic        rv_b, busy_b, err_b;

   dm_param #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .WORD0_INIT(8'hFF)) dut_a (
      .clk(clk), .reset(reset_a), .mem_write(we_a), .mem_read(re_a),
      .address(addr_a), .write_data(wd_a), .byte_en(be_a),
      .read_data(rd_a), .read_valid(rv_a), .busy(busy_a), .addr_err(err_a)
   );

   dm_param #(.DATA_W(32), .ADDR_W(8), .DEPTH(200), .WORD0_INIT(32'h0000_00FF)) dut_b (
      .clk(clk), .reset(reset_b), .mem_write(we_b), .mem_read(re_b),
      .address(addr_b), .write_data(wd_b), .byte_en(be_b),
      .read_data(rd_b), .read_valid(rv_b), .busy(busy_b), .addr_err(err_b)
   );

   typedef struct {
      logic        we;
      logic        re;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic        exp_valid;
      logic [31:0] exp_data;
      logic        exp_err;
   } vec_t;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_a();
      we_a = 0; re_a = 0; addr_a = 0; wd_a = 0; be_a = 0;
   endtask

   task automatic idle_b();
      we_b = 0; re_b = 0; addr_b = 0; wd_b = 0; be_b = 0;
   endtask

   // Applies one record to the selected instance and checks the registered
   // result one clock later.
   task automatic apply(input bit sel_b, input vec_t v, input string tag);
      if (!sel_b) begin
         we_a = v.we; re_a = v.re; addr_a = v.addr; wd_a = v.wdata[7:0]; be_a = v.be[0:0];
      end else begin
         we_b = v.we; re_b = v.re; addr_b = v.addr; wd_b = v.wdata; be_b = v.be;
      end
      @(posedge clk); #1;
      if (!sel_b) begin
         chk({tag, " valid"}, {31'b0, rv_a}, {31'b0, v.exp_valid});
         chk({tag, " data"},  {24'b0, rd_a}, v.exp_data);
         chk({tag, " err"},   {31'b0, err_a}, {31'b0, v.exp_err});
      end else begin
         chk({tag, " valid"}, {31'b0, rv_b}, {31'b0, v.exp_valid});
         chk({tag, " data"},  rd_b, v.exp_data);
         chk({tag, " err"},   {31'b0, err_b}, {31'b0, v.exp_err});
      end
   endtask

   // Counts busy cycles from the current sample point while issuing reads,
   // and checks that no read_valid / addr_err leaks out during the clear.
   task automatic count_busy(input bit sel_b, input int exp_cnt, input string tag);
      int cnt;
      int leaks;
      cnt = 0;
      leaks = 0;
      if (!sel_b) begin re_a = 1; we_a = 1; addr_a = 8'd7; wd_a = 8'h3C; be_a = 1'b1; end
      else        begin re_b = 1; addr_b = 8'd250; end
      while ((sel_b ? busy_b : busy_a) && cnt < 1000) begin
         cnt++;
         @(posedge clk); #1;
         if (!sel_b && (rv_a || err_a)) leaks++;
         if (sel_b && (rv_b || err_b)) leaks++;
      end
      if (!sel_b) idle_a(); else idle_b();
      chk({tag, " busy cycles"}, cnt, exp_cnt);
      chk({tag, " strobes while busy"}, leaks, 0);
   endtask

   vec_t tab_a[14];
   vec_t tab_b[10];

   initial begin
      //           we re addr   wdata          be   v  data           err
      tab_a[0]  = '{0, 1, 8'd0,   32'h0,        4'h0, 1, 32'hFF,        0};
      tab_a[1]  = '{0, 1, 8'd1,   32'h0,        4'h0, 1, 32'h00,        0};
      tab_a[2]  = '{1, 0, 8'd10,  32'hAA,       4'h1, 0, 32'h00,        0};
      tab_a[3]  = '{0, 1, 8'd10,  32'h0,        4'h0, 1, 32'hAA,        0};
      tab_a[4]  = '{1, 0, 8'd20,  32'h55,       4'h1, 0, 32'hAA,        0};
      tab_a[5]  = '{0, 1, 8'd20,  32'h0,        4'h0, 1, 32'h55,        0};
      tab_a[6]  = '{0, 1, 8'd10,  32'h0,        4'h0, 1, 32'hAA,        0};
      tab_a[7]  = '{1, 1, 8'd3,   32'h77,       4'h1, 1, 32'h00,        0};
      tab_a[8]  = '{0, 1, 8'd3,   32'h0,        4'h0, 1, 32'h77,        0};
      tab_a[9]  = '{1, 0, 8'd255, 32'h12,       4'h0, 0, 32'h77,        0};
      tab_a[10] = '{0, 1, 8'd255, 32'h0,        4'h0, 1, 32'h00,        0};
      tab_a[11] = '{0, 0, 8'd0,   32'h0,        4'h0, 0, 32'h00,        0};
      tab_a[12] = '{1, 0, 8'd255, 32'h5A,       4'h1, 0, 32'h00,        0};
      tab_a[13] = '{0, 1, 8'd255, 32'h0,        4'h0, 1, 32'h5A,        0};

      tab_b[0]  = '{1, 0, 8'd5,   32'h11223344, 4'hF, 0, 32'h0,         0};
      tab_b[1]  = '{1, 0, 8'd5,   32'hAABBCCDD, 4'h5, 0, 32'h0,         0};
      tab_b[2]  = '{0, 1, 8'd5,   32'h0,        4'h0, 1, 32'h11BB33DD,  0};
      tab_b[3]  = '{1, 0, 8'd250, 32'hDEADBEEF, 4'hF, 0, 32'h11BB33DD,  1};
      tab_b[4]  = '{0, 1, 8'd250, 32'h0,        4'h0, 1, 32'h0,         1};
      tab_b[5]  = '{0, 1, 8'd199, 32'h0,        4'h0, 1, 32'h0,         0};
      tab_b[6]  = '{0, 1, 8'd0,   32'h0,        4'h0, 1, 32'h000000FF,  0};
      tab_b[7]  = '{1, 0, 8'd200, 32'h01020304, 4'hF, 0, 32'h000000FF,  1};
      tab_b[8]  = '{0, 1, 8'd5,   32'h0,        4'h0, 1, 32'h11BB33DD,  0};
      tab_b[9]  = '{0, 1, 8'd50,  32'h0,        4'h0, 1, 32'h0,         0};

      idle_a();
      idle_b();
      reset_a = 1;
      reset_b = 1;
      @(posedge clk); #1;
      reset_a = 0;
      reset_b = 0;

      chk("reset busy_a", {31'b0, busy_a}, 32'd1);
      chk("reset rd_a",   {24'b0, rd_a},   32'd0);
      chk("reset rv_a",   {31'b0, rv_a},   32'd0);
      chk("reset err_a",  {31'b0, err_a},  32'd0);
      chk("reset busy_b", {31'b0, busy_b}, 32'd1);

      // Instance A clears first while reads/writes are held high; B's clear
      // finishes during that time, so B is idle and READY afterwards.
      count_busy(0, 256, "a init");
      chk("a busy low", {31'b0, busy_a}, 32'd0);
      for (int i = 0; i < 14; i++) apply(0, tab_a[i], $sformatf("a vec%0d", i));
      idle_a();

      // B was released together with A; confirm it is READY and idle.
      chk("b busy low", {31'b0, busy_b}, 32'd0);
      for (int i = 0; i < 10; i++) apply(1, tab_b[i], $sformatf("b vec%0d", i));
      idle_b();

      // Dirty word 0, then reset mid-clear at ptr=50 and check a full restart.
      apply(1, '{1, 0, 8'd0, 32'hCAFEF00D, 4'hF, 0, 32'h0, 0}, "b dirty w0");
      reset_b = 1;
      @(posedge clk); #1;
      reset_b = 0;
      for (int i = 0; i < 50; i++) begin @(posedge clk); #1; end
      chk("b busy mid init", {31'b0, busy_b}, 32'd1);
      reset_b = 1;
      @(posedge clk); #1;
      reset_b = 0;
      chk("b rd after reset", rd_b, 32'd0);
      count_busy(1, 200, "b reinit");
      apply(1, '{0, 1, 8'd0, 32'h0, 4'h0, 1, 32'h000000FF, 0}, "b w0 after reinit");
      apply(1, '{0, 1, 8'd5, 32'h0, 4'h0, 1, 32'h0, 0},        "b w5 after reinit");
      idle_b();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
